commit_trace_buffer: RTL

- Sits directly downstream of core_model's commit/retire outputs.
- Captures each retired instruction (pc, instr, register writeback, memory access) into a classified trace record and buffers records in a FIFO.
- Records drain through a valid/ready port to a logger or UART sink.
- Also maintains cycle and retired-instruction counters for CPI, and detects the end-of-test self-loop instruction.

---
 rtl/commit_trace_buffer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures retired instructions from the core commit port into classified
//   trace records, buffers them in a show-ahead FIFO and drains them to a
//   sink. Also keeps cycle / instret counters and detects the end-of-test
//   self-loop instruction.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   update_i ... mem_size_i   commit-side inputs from the core
//   rec_ready_i         sink accepts the presented record
//   rec_valid_o, rec_*  record presented to the sink (all zero when empty)
//   level_o             FIFO occupancy
//   cycle_cnt_o         cycles since reset (frozen after halt)
//   instret_o           accepted commits, including dropped ones
//   drop_cnt_o          records lost to overflow (saturating)
//   overflow_o          sticky: a record was dropped
//   halt_o              sticky: END_INSTR committed (FSM state RUN/HALTED)
//
// Handshake: a record transfers on any clock edge where rec_valid_o and
// rec_ready_i are both high; while rec_valid_o is high and rec_ready_i is low
// the rec_* outputs hold stable.
module commit_trace_buffer #(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] END_INSTR = 32'h0000006f
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       update_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [31:0]                instr_i,
  input  logic [4:0]                 reg_addr_i,
  input  logic [XLEN-1:0]            reg_data_i,
  input  logic                       reg_we_i,
  input  logic                       mem_re_i,
  input  logic                       mem_we_i,
  input  logic [XLEN-1:0]            mem_read_addr_i,
  input  logic [XLEN-1:0]            mem_write_addr_i,
  input  logic [XLEN-1:0]            mem_write_data_i,
  input  logic [1:0]                 mem_size_i,
  input  logic                       rec_ready_i,
  output logic                       rec_valid_o,
  output logic [1:0]                 rec_kind_o,
  output logic [XLEN-1:0]            rec_pc_o,
  output logic [31:0]                rec_instr_o,
  output logic [4:0]                 rec_rd_o,
  output logic [XLEN-1:0]            rec_data_o,
  output logic [XLEN-1:0]            rec_addr_o,
  output logic [1:0]                 rec_size_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [63:0]                cycle_cnt_o,
  output logic [63:0]                instret_o,
  output logic [31:0]                drop_cnt_o,
  output logic                       overflow_o,
  output logic                       halt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [1:0] K_PLAIN = 2'd0;
  localparam logic [1:0] K_REG   = 2'd1;
  localparam logic [1:0] K_LOAD  = 2'd2;
  localparam logic [1:0] K_STORE = 2'd3;

  typedef enum logic { ST_RUN, ST_HALTED } state_t;

  typedef struct packed {
    logic [1:0]      kind;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] addr;
    logic [1:0]      size;
  } rec_t;

  state_t          state_q;
  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]   count_q, count_d;
  logic [63:0]     cycle_q, instret_q;
  logic [31:0]     drop_q;
  logic            ovf_q;

  logic            accept, full, pop, push, drop;
  rec_t            rec_new, head;
  logic [XLEN-1:0] store_data;

  always_comb begin
    accept = update_i && (pc_i != '0) && (state_q == ST_RUN);
    full   = (count_q == FULL_LVL);
    pop    = (count_q != '0) && rec_ready_i;
    // When full, a same-cycle pop frees the slot the push lands in.
    push   = accept && (!full || pop);
    drop   = accept && full && !pop;
  end

  always_comb begin
    case (mem_size_i)
      2'b00:   store_data = {{(XLEN-8){1'b0}},  mem_write_data_i[7:0]};
      2'b01:   store_data = {{(XLEN-16){1'b0}}, mem_write_data_i[15:0]};
      default: store_data = mem_write_data_i;
    endcase
  end

  always_comb begin
    rec_new       = '0;
    rec_new.pc    = pc_i;
    rec_new.instr = instr_i;
    rec_new.size  = mem_size_i;
    if (mem_we_i) begin
      rec_new.kind = K_STORE;
      rec_new.data = store_data;
      rec_new.addr = mem_write_addr_i;
    end else if (mem_re_i && reg_addr_i != 5'd0) begin
      rec_new.kind = K_LOAD;
      rec_new.rd   = reg_addr_i;
      rec_new.data = reg_data_i;
      rec_new.addr = mem_read_addr_i;
    end else if (reg_we_i && reg_addr_i != 5'd0) begin
      rec_new.kind = K_REG;
      rec_new.rd   = reg_addr_i;
      rec_new.data = reg_data_i;
    end else begin
      rec_new.kind = K_PLAIN;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; rec_* are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (state_q == ST_RUN) cycle_q <= cycle_q + 64'd1;
      if (accept) instret_q <= instret_q + 64'd1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 32'd1;
      end
      case (state_q)
        ST_RUN:    if (accept && instr_i == END_INSTR) state_q <= ST_HALTED;
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    rec_valid_o = (count_q != '0);
    rec_kind_o  = rec_valid_o ? head.kind  : '0;
    rec_pc_o    = rec_valid_o ? head.pc    : '0;
    rec_instr_o = rec_valid_o ? head.instr : '0;
    rec_rd_o    = rec_valid_o ? head.rd    : '0;
    rec_data_o  = rec_valid_o ? head.data  : '0;
    rec_addr_o  = rec_valid_o ? head.addr  : '0;
    rec_size_o  = rec_valid_o ? head.size  : '0;
  end

  assign level_o     = count_q;
  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;
  assign drop_cnt_o  = drop_q;
  assign overflow_o  = ovf_q;
  assign halt_o      = (state_q == ST_HALTED);

endmodule
